sram_dp_be: RTL and testbench
=============================

SRAM_DP_BE -- requirements
Module: sram_dp_be

Interface
REQ-001 SHALL have parameter DEPTH, default 16: number of words, 2 or more, need not be a power of two.
REQ-002 SHALL have parameter DATA_WIDTH, default 32: word width in bits.
REQ-003 SHALL have parameter LANE_W, default 8: byte-lane width; DATA_WIDTH not a multiple of LANE_W is an elaboration error.
REQ-004 SHALL have parameter READ_LATENCY, default 1: cycles from rd_en sample to rd_valid, legal range 1..4, others an elaboration error.
REQ-005 SHALL have parameter RDW_NEW, default 0: read-during-write policy; 0 returns old data, 1 returns new data.
REQ-006 SHALL derive localparams ADDR_W = max(1, clog2(DEPTH)) and NLANES = DATA_WIDTH/LANE_W.
REQ-007 SHALL have port clk, input, 1 bit: clock, all state on rising edge.
REQ-008 SHALL have port rst, input, 1 bit: reset, asynchronous, active-high.
REQ-009 SHALL have port clr_req, input, 1 bit: request full-array clear.
REQ-010 SHALL have port clr_busy, output, 1 bit: clear sweep in progress.
REQ-011 SHALL have port wr_en, input, 1 bit: write strobe.
REQ-012 SHALL have port wr_addr, input, ADDR_W bits: write address.
REQ-013 SHALL have port wr_data, input, DATA_WIDTH bits: write data.
REQ-014 SHALL have port wr_be, input, NLANES bits: lane enables; bit i covers wr_data[i*LANE_W +: LANE_W].
REQ-015 SHALL have port rd_en, input, 1 bit: read strobe.
REQ-016 SHALL have port rd_addr, input, ADDR_W bits: read address.
REQ-017 SHALL have port rd_data, output, DATA_WIDTH bits: read data.
REQ-018 SHALL have port rd_valid, output, 1 bit: rd_data valid this cycle.
REQ-019 SHALL have port err_oob, output, 1 bit: one-cycle pulse for an out-of-range access.

Function
REQ-020 SHALL implement a two-state FSM, IDLE and CLEAR; clr_busy = (state == CLEAR).
REQ-021 In CLEAR, SHALL write zero to one address per cycle, ascending 0..DEPTH-1, then go to IDLE on the cycle after writing DEPTH-1; the sweep lasts exactly DEPTH cycles.
REQ-022 In IDLE, clr_req sampled high SHALL enter CLEAR next cycle; clr_req during CLEAR SHALL be ignored and SHALL NOT restart the sweep.
REQ-023 During CLEAR, wr_en and rd_en SHALL be ignored: no memory update, no rd_valid, no err_oob.
REQ-024 In IDLE, wr_en with wr_addr < DEPTH SHALL update only the lanes whose wr_be bit is set; lanes with wr_be bit clear SHALL be preserved; wr_be == 0 is a no-op.
REQ-025 In IDLE, rd_en sampled at edge N SHALL assert rd_valid for exactly one cycle starting at edge N+READ_LATENCY-1, with rd_data holding the addressed word.
REQ-026 Reads SHALL be fully pipelined: one read accepted per cycle, results returned in issue order, no stalls.
REQ-027 rd_data SHALL hold its last value while rd_valid is low.
REQ-028 Read and write to the same address in the same cycle, RDW_NEW=0: SHALL return the pre-write word.
REQ-029 Read and write to the same address in the same cycle, RDW_NEW=1: SHALL return the lane-merged post-write word.
REQ-030 A write with wr_addr >= DEPTH SHALL be dropped.
REQ-031 A read with rd_addr >= DEPTH SHALL complete with normal latency and rd_valid, returning all-zero data.
REQ-032 Any out-of-range read or write accepted in IDLE SHALL pulse err_oob on the following cycle; simultaneous out-of-range read and write SHALL give a single pulse.
REQ-033 The memory array SHALL have no reset term, so it maps to RAM; zeroing happens only by the clear sweep.

Reset
REQ-034 While rst is high, SHALL hold: rd_data=0, rd_valid=0, err_oob=0, read pipeline empty, clear address=0, state=CLEAR, clr_busy=1.
REQ-035 On rst deassertion, SHALL start the automatic clear sweep from address 0, lasting DEPTH cycles.
REQ-036 rst mid-read or mid-sweep SHALL discard in-flight reads, with no rd_valid for them, and restart the sweep from 0.

Verification (DEPTH=16, DATA_WIDTH=16, LANE_W=8, READ_LATENCY=2 unless noted)
REQ-037 Release rst: clr_busy high exactly 16 cycles; then reads of addresses 0..15 return 0x0000.
REQ-038 Write addr 3 = 0xABCD with be=11, then write addr 3 = 0x1234 with be=01; read addr 3 -> 0xAB34, rd_valid 2 edges after rd_en.
REQ-039 Addr 5 holds 0x1111; same-cycle write 0x2222 (be=11) and read of addr 5 -> 0x1111 with RDW_NEW=0, 0x2222 with RDW_NEW=1.
REQ-040 DEPTH=12: write addr 13 = 0xFFFF -> err_oob pulse next cycle; read addr 13 -> 0x0000 with rd_valid; addrs 0..11 unchanged.
REQ-041 Back-to-back reads of addrs 0..3 holding 0x00A0..0x00A3 -> rd_valid high 4 consecutive cycles, data in order.
REQ-042 clr_req after writes, plus rd_en pulsed during the sweep -> clr_busy 16 cycles, no rd_valid; afterwards all words 0x0000. rst asserted mid-sweep -> sweep restarts, 16 more busy cycles.

Source files
------------

// File: rtl/sram_dp_be.sv
// Dual-port byte-lane-enabled SRAM with a pipelined read path and a
// self-timed zeroing sweep that runs after reset or on request.
module sram_dp_be #(
   parameter int DEPTH        = 16,
   parameter int DATA_WIDTH   = 32,
   parameter int LANE_W       = 8,
   parameter int READ_LATENCY = 1,
   parameter int RDW_NEW      = 0,
   localparam int ADDR_W      = (DEPTH <= 2) ? 1 : $clog2(DEPTH),
   localparam int NLANES      = DATA_WIDTH / LANE_W
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  clr_req,
   output logic                  clr_busy,
   input  logic                  wr_en,
   input  logic [ADDR_W-1:0]     wr_addr,
   input  logic [DATA_WIDTH-1:0] wr_data,
   input  logic [NLANES-1:0]     wr_be,
   input  logic                  rd_en,
   input  logic [ADDR_W-1:0]     rd_addr,
   output logic [DATA_WIDTH-1:0] rd_data,
   output logic                  rd_valid,
   output logic                  err_oob
);

   generate
      if (DATA_WIDTH % LANE_W != 0) begin : g_bad_lane
         $error("sram_dp_be: DATA_WIDTH must be a multiple of LANE_W");
      end
      if (READ_LATENCY < 1 || READ_LATENCY > 4) begin : g_bad_lat
         $error("sram_dp_be: READ_LATENCY must be in 1..4");
      end
      if (DEPTH < 2) begin : g_bad_depth
         $error("sram_dp_be: DEPTH must be at least 2");
      end
   endgenerate

   // One extra bit so DEPTH itself is representable when it is a power of two.
   localparam logic [ADDR_W:0]   DEPTH_C   = (ADDR_W+1)'(DEPTH);
   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

   typedef enum logic {IDLE = 1'b0, CLEAR = 1'b1} state_t;

   state_t                                   state_q;
   logic [ADDR_W-1:0]                        clr_addr_q;
   logic                                     clr_busy_q;
   logic [DATA_WIDTH-1:0]                    mem [DEPTH];
   logic [READ_LATENCY-1:0]                  vld_pipe_q, vld_pipe_d;
   logic [READ_LATENCY-1:0][DATA_WIDTH-1:0]  dat_pipe_q, dat_pipe_d;
   logic                                     err_oob_q, err_oob_d;

   logic                  idle, wr_inr, rd_inr, wr_go, rd_go;
   logic [DATA_WIDTH-1:0] rd_word;

   assign idle   = (state_q == IDLE);
   assign wr_inr = ({1'b0, wr_addr} < DEPTH_C);
   assign rd_inr = ({1'b0, rd_addr} < DEPTH_C);
   assign wr_go  = idle & wr_en & wr_inr;
   assign rd_go  = idle & rd_en;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= CLEAR;
         clr_addr_q <= '0;
         clr_busy_q <= 1'b1;
      end else begin
         case (state_q)
            IDLE: begin
               if (clr_req) begin
                  state_q    <= CLEAR;
                  clr_addr_q <= '0;
                  clr_busy_q <= 1'b1;
               end
            end
            CLEAR: begin
               if (clr_addr_q == LAST_ADDR) begin
                  state_q    <= IDLE;
                  clr_addr_q <= '0;
                  clr_busy_q <= 1'b0;
               end else begin
                  clr_addr_q <= clr_addr_q + ADDR_W'(1);
               end
            end
            default: begin
               state_q    <= CLEAR;
               clr_addr_q <= '0;
               clr_busy_q <= 1'b1;
            end
         endcase
      end
   end

   // Array has no reset so it maps onto RAM; the sweep owns the write port while busy.
   always_ff @(posedge clk) begin
      if (state_q == CLEAR) begin
         mem[clr_addr_q] <= '0;
      end else if (wr_go) begin
         for (int l = 0; l < NLANES; l++) begin
            if (wr_be[l]) mem[wr_addr][l*LANE_W +: LANE_W] <= wr_data[l*LANE_W +: LANE_W];
         end
      end
   end

   always_comb begin
      rd_word = '0;
      if (rd_inr) begin
         rd_word = mem[rd_addr];
         if (RDW_NEW != 0 && wr_go && wr_addr == rd_addr) begin
            for (int l = 0; l < NLANES; l++) begin
               if (wr_be[l]) rd_word[l*LANE_W +: LANE_W] = wr_data[l*LANE_W +: LANE_W];
            end
         end
      end
   end

   // Each stage only loads on a valid, so the last stage holds rd_data between reads.
   always_comb begin
      vld_pipe_d    = '0;
      dat_pipe_d    = dat_pipe_q;
      vld_pipe_d[0] = rd_go;
      if (rd_go) dat_pipe_d[0] = rd_word;
      for (int k = 1; k < READ_LATENCY; k++) begin
         vld_pipe_d[k] = vld_pipe_q[k-1];
         if (vld_pipe_q[k-1]) dat_pipe_d[k] = dat_pipe_q[k-1];
      end
      err_oob_d = idle & ((wr_en & ~wr_inr) | (rd_en & ~rd_inr));
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         vld_pipe_q <= '0;
         dat_pipe_q <= '0;
         err_oob_q  <= 1'b0;
      end else begin
         vld_pipe_q <= vld_pipe_d;
         dat_pipe_q <= dat_pipe_d;
         err_oob_q  <= err_oob_d;
      end
   end

   assign clr_busy = clr_busy_q;
   assign rd_valid = vld_pipe_q[READ_LATENCY-1];
   assign rd_data  = dat_pipe_q[READ_LATENCY-1];
   assign err_oob  = err_oob_q;

endmodule

// File: tb/tb_sram_dp_be.sv
// Drives two memories (16 words old-data RDW, 12 words new-data RDW) from one
// stimulus stream and compares both against a time-stamped array model.
module tb_sram_dp_be;
   logic        clk = 1'b0, rst = 1'b1, clr_req = 1'b0, wr_en = 1'b0, rd_en = 1'b0;
   logic [3:0]  wr_addr = '0, rd_addr = '0;
   logic [15:0] wr_data = '0;
   logic [1:0]  wr_be = '0;

   logic        a_clr_busy, a_rd_valid, a_err_oob, b_clr_busy, b_rd_valid, b_err_oob;
   logic [15:0] a_rd_data, b_rd_data;

   sram_dp_be #(.DEPTH(16), .DATA_WIDTH(16), .LANE_W(8), .READ_LATENCY(2), .RDW_NEW(0)) u_a (
      .clk(clk), .rst(rst), .clr_req(clr_req), .clr_busy(a_clr_busy),
      .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_be(wr_be),
      .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(a_rd_data), .rd_valid(a_rd_valid),
      .err_oob(a_err_oob));

   sram_dp_be #(.DEPTH(12), .DATA_WIDTH(16), .LANE_W(8), .READ_LATENCY(2), .RDW_NEW(1)) u_b (
      .clk(clk), .rst(rst), .clr_req(clr_req), .clr_busy(b_clr_busy),
      .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_be(wr_be),
      .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(b_rd_data), .rd_valid(b_rd_valid),
      .err_oob(b_err_oob));

   always #5 clk = ~clk;

   logic [1:0]       o_busy, o_vld, o_err;
   logic [1:0][15:0] o_data;
   assign o_busy = {b_clr_busy, a_clr_busy};
   assign o_vld  = {b_rd_valid, a_rd_valid};
   assign o_err  = {b_err_oob, a_err_oob};
   assign o_data = {b_rd_data, a_rd_data};

   int          n_chk = 0, n_fail = 0, ncyc = 0;
   int          dep [2];
   bit          rdw [2];
   int          busy_left [2];
   logic [15:0] m [2][16];
   bit          sv [2][8];        // read result due at cycle (slot index = cycle mod 8)
   logic [15:0] sd [2][8];
   logic [15:0] exp_d [2];
   bit          exp_err [2];

   task automatic chk(string tag, logic [15:0] obs, logic [15:0] exp_v);
      n_chk++;
      assert (obs === exp_v) else begin
         n_fail++;
         $error("FAIL %s @cyc %0d: observed %h expected %h", tag, ncyc, obs, exp_v);
      end
   endtask

   task automatic model_edge();
      logic [15:0] old_w;
      int slot;
      ncyc++;
      slot = (ncyc + 1) % 8;
      for (int k = 0; k < 2; k++) begin
         exp_err[k] = 1'b0;
         if (rst) begin
            busy_left[k] = dep[k];
            exp_d[k] = '0;
            for (int s = 0; s < 8; s++) sv[k][s] = 1'b0;
            for (int a = 0; a < 16; a++) m[k][a] = '0;
         end else if (busy_left[k] > 0) begin
            busy_left[k]--;
         end else begin
            old_w = (int'(rd_addr) < dep[k]) ? m[k][rd_addr] : 16'h0000;
            if (wr_en) begin
               if (int'(wr_addr) < dep[k]) begin
                  for (int l = 0; l < 2; l++)
                     if (wr_be[l]) m[k][wr_addr][l*8 +: 8] = wr_data[l*8 +: 8];
               end else exp_err[k] = 1'b1;
            end
            if (rd_en) begin
               sv[k][slot] = 1'b1;
               if (int'(rd_addr) >= dep[k]) begin
                  sd[k][slot] = '0;
                  exp_err[k] = 1'b1;
               end else sd[k][slot] = rdw[k] ? m[k][rd_addr] : old_w;
            end
            if (clr_req) begin
               for (int a = 0; a < 16; a++) m[k][a] = '0;
               busy_left[k] = dep[k];
            end
         end
      end
   endtask

   task automatic step();
      int slot;
      bit v;
      model_edge();
      @(posedge clk);
      #1;
      slot = ncyc % 8;
      for (int k = 0; k < 2; k++) begin
         v = sv[k][slot];
         sv[k][slot] = 1'b0;
         if (v) exp_d[k] = sd[k][slot];
         chk($sformatf("clr_busy%0d", k), 16'(o_busy[k]), 16'(busy_left[k] > 0));
         chk($sformatf("rd_valid%0d", k), 16'(o_vld[k]),  16'(v));
         chk($sformatf("rd_data%0d", k),  o_data[k],      exp_d[k]);
         chk($sformatf("err_oob%0d", k),  16'(o_err[k]),  16'(exp_err[k]));
      end
   endtask

   task automatic op(input bit we, input logic [3:0] wa, input logic [15:0] wd,
                     input logic [1:0] be, input bit re, input logic [3:0] ra, input bit cr);
      wr_en = we; wr_addr = wa; wr_data = wd; wr_be = be;
      rd_en = re; rd_addr = ra; clr_req = cr;
      step();
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) op(0, 0, 16'h0, 2'b00, 0, 0, 0);
   endtask

   initial begin
      dep[0] = 16; dep[1] = 12;
      rdw[0] = 1'b0; rdw[1] = 1'b1;
      for (int k = 0; k < 2; k++) begin
         busy_left[k] = dep[k]; exp_d[k] = '0; exp_err[k] = 1'b0;
         for (int s = 0; s < 8; s++) begin sv[k][s] = 1'b0; sd[k][s] = '0; end
         for (int a = 0; a < 16; a++) m[k][a] = '0;
      end

      // reset held, then the automatic sweep and a full read-back
      rst = 1'b1; idle(3);
      rst = 1'b0; idle(17);
      for (int i = 0; i < 16; i++) op(0, 0, 0, 0, 1, 4'(i), 0);
      idle(2);

      // lane merge
      op(1, 3, 16'hABCD, 2'b11, 0, 0, 0);
      op(1, 3, 16'h1234, 2'b01, 0, 0, 0);
      op(0, 0, 0, 0, 1, 3, 0);
      op(1, 3, 16'h5678, 2'b00, 0, 0, 0);
      op(0, 0, 0, 0, 1, 3, 0);
      idle(2);

      // read-during-write on the same address
      op(1, 5, 16'h1111, 2'b11, 0, 0, 0);
      op(1, 5, 16'h2222, 2'b11, 1, 5, 0);
      op(1, 5, 16'h3333, 2'b10, 1, 5, 0);
      idle(2);

      // address 13: valid for the 16-word part, out of range for the 12-word part
      op(1, 13, 16'hFFFF, 2'b11, 0, 0, 0);
      op(0, 0, 0, 0, 1, 13, 0);
      op(1, 14, 16'hBEEF, 2'b11, 1, 15, 0);
      for (int i = 0; i < 12; i++) op(0, 0, 0, 0, 1, 4'(i), 0);
      idle(2);

      // back-to-back reads
      for (int i = 0; i < 4; i++) op(1, 4'(i), 16'h00A0 + 16'(i), 2'b11, 0, 0, 0);
      for (int i = 0; i < 4; i++) op(0, 0, 0, 0, 1, 4'(i), 0);
      idle(3);

      // requested clear with reads/writes poked during the sweep
      op(0, 0, 0, 0, 0, 0, 1);
      for (int i = 0; i < 16; i++) op(i % 2 == 1, 4'(i), 16'hFFFF, 2'b11, i % 2 == 0, 4'(i), i == 4);
      idle(2);
      for (int i = 0; i < 16; i++) op(0, 0, 0, 0, 1, 4'(i), 0);
      idle(2);

      // reset in the middle of a sweep and mid-read
      op(1, 7, 16'h7777, 2'b11, 0, 0, 1);
      idle(5);
      op(0, 0, 0, 0, 0, 0, 0);
      rst = 1'b1; idle(1);
      rst = 1'b0; idle(18);
      op(1, 2, 16'h4242, 2'b11, 1, 7, 0);
      rst = 1'b1; idle(1);
      rst = 1'b0; idle(18);

      // random traffic
      for (int i = 0; i < 700; i++) begin
         rst = ($urandom_range(0, 299) == 0);
         op($urandom_range(0, 1) == 1, 4'($urandom_range(0, 15)), 16'($urandom),
            2'($urandom_range(0, 3)), $urandom_range(0, 1) == 1,
            4'($urandom_range(0, 15)), $urandom_range(0, 79) == 0);
      end
      rst = 1'b0;
      idle(20);
      for (int i = 0; i < 16; i++) op(0, 0, 0, 0, 1, 4'(i), 0);
      idle(3);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
